// File: rtl/mp_add_pkg.sv
// Shared types and constants for the sequential multi-precision adder.
package mp_add_pkg;

    localparam int unsigned SLICE_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/add_slice8.sv
// Combinational 8-bit slice adder; co is the full ninth bit of the add.
module add_slice8 (
    input  logic [7:0] a8,
    input  logic [7:0] b8,
    input  logic       ci,
    output logic [7:0] s8,
    output logic       co
);

    assign {co, s8} = {1'b0, a8} + {1'b0, b8} + {8'd0, ci};

endmodule

// File: rtl/mp_add_seq.sv
// Sequential multi-precision adder: one 8-bit slice per cycle through a shared add_slice8.
// Define MP_ADD_SEQ_SUB_EN to add the sub input (a - b, cout=1 means no borrow).
module mp_add_seq
    import mp_add_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned SLICE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  cin,
`ifdef MP_ADD_SEQ_SUB_EN
    input  logic                  sub,
`endif
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  cout,
    output logic                  busy
);

    localparam int unsigned N  = DATA_WIDTH / 8;
    localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned IW = KW + 3;

    if (SLICE_WIDTH != mp_add_pkg::SLICE_WIDTH) begin : g_bad_slice
        $error("mp_add_seq: SLICE_WIDTH must be 8");
    end
    if (DATA_WIDTH < 8 || DATA_WIDTH > 64 || (DATA_WIDTH % 8) != 0) begin : g_bad_width
        $error("mp_add_seq: DATA_WIDTH must be a multiple of 8 in 8..64");
    end

    logic sub_eff;
`ifdef MP_ADD_SEQ_SUB_EN
    assign sub_eff = sub;
`else
    assign sub_eff = 1'b0;
`endif

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic [KW-1:0]         k_q, k_d;
    logic                  cy_q, cy_d, cout_q, cout_d;

    logic [IW-1:0]         idx;
    logic [DATA_WIDTH-1:0] a_sh, b_sh;
    logic [7:0]            s8;
    logic                  co;
    logic                  last_slice;

    assign idx        = {k_q, 3'b000};
    assign a_sh       = a_q >> idx;
    assign b_sh       = b_q >> idx;
    assign last_slice = (k_q == KW'(N - 1));

    add_slice8 u_slice (
        .a8 (a_sh[7:0]),
        .b8 (b_sh[7:0]),
        .ci (cy_q),
        .s8 (s8),
        .co (co)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; no DONE->RUN bypass, so IDLE always sits between operations
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)   state_d = RUN;
            RUN:     if (last_slice) state_d = DONE;
            DONE:    if (out_ready)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from state only
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state_q)
            IDLE:    in_ready  = 1'b1;
            RUN:     busy      = 1'b1;
            DONE:    begin out_valid = 1'b1; busy = 1'b1; end
            default: ;
        endcase
    end

    // Datapath next values: operand capture at accept, one slice written per RUN cycle
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        k_d    = k_q;
        cy_d   = cy_q;
        sum_d  = sum_q;
        cout_d = cout_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d  = a;
                    b_d  = sub_eff ? ~b : b;
                    cy_d = sub_eff ? 1'b1 : cin;
                    k_d  = '0;
                end
            end
            RUN: begin
                sum_d[idx +: 8] = s8;
                cy_d            = co;
                k_d             = k_q + KW'(1);
                if (last_slice) begin
                    cout_d = co;
                    k_d    = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q    <= '0;
            b_q    <= '0;
            k_q    <= '0;
            cy_q   <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            k_q    <= k_d;
            cy_q   <= cy_d;
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: doc/mp_add_seq.md
MP_ADD_SEQ -- requirements
Module: mp_add_seq

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, total operand width; legal values are multiples of 8 from 8 to 64.
REQ-002 SHALL have parameter SLICE_WIDTH, default 8, slice adder width; fixed at 8, and any other value SHALL be an elaboration error.
REQ-003 SHALL have ports, in order:
  clk  in  1  single clock, rising edge.
  rst  in  1  synchronous active-high reset.
  in_valid  in  1  operand offer.
  in_ready  out  1  block can accept operands.
  a  in  DATA_WIDTH  operand A.
  b  in  DATA_WIDTH  operand B.
  cin  in  1  carry-in to slice 0.
  out_valid  out  1  result available.
  out_ready  in  1  consumer accepts result.
  sum  out  DATA_WIDTH  assembled sum.
  cout  out  1  carry-out of top slice.
  busy  out  1  high in RUN or DONE.
REQ-004 Clocking and reset SHALL be as follows: one clock (clk); reset (rst) is synchronous and active-high.

Function
REQ-005 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-006 In IDLE, in_ready SHALL be 1; in_valid&&in_ready SHALL capture a, b and cin into registers, clear the slice index to 0, and move the FSM to RUN.
REQ-007 In RUN, each cycle SHALL add slice k of A_reg and B_reg plus the carry register (cin_reg when k=0), write the 8-bit result into sum_reg[8k+7:8k], and register the slice carry.
REQ-008 The RUN slice index SHALL increment from 0 to N-1, where N=DATA_WIDTH/8; on k=N-1 the FSM SHALL go to DONE and cout_reg SHALL take the final carry.
REQ-009 In DONE, out_valid SHALL be 1 and sum/cout SHALL hold stable until out_ready; on out_valid&&out_ready the FSM SHALL go to IDLE.
REQ-010 Latency from the accept edge to the first out_valid cycle SHALL be N+1 cycles (5 for DATA_WIDTH=32), independent of out_ready.
REQ-011 in_ready SHALL be 0 in RUN and DONE; in_valid in those states SHALL be ignored, and operands SHALL NOT be overwritten.
REQ-012 No same-cycle DONE->RUN bypass: the next accept SHALL occur at the earliest one cycle after the result handshake, giving a throughput of one operation per N+2 cycles with out_ready=1.
REQ-013 All arithmetic SHALL be modulo 2^DATA_WIDTH, with the overflow carry reported only on cout.
REQ-014 The slice carry SHALL be the true 9th bit of the 8-bit add, with no truncation.
REQ-015 sum and cout SHALL be driven directly from registers, with no combinational path from inputs.
REQ-016 out_valid SHALL depend only on state; in_ready SHALL depend only on state.
REQ-017 The DATA_WIDTH=8 boundary SHALL give a single RUN cycle, with a latency of 2.

Reset
REQ-018 rst high at a clock edge SHALL force IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, slice index=0 and carry=0.
REQ-019 Reset asserted mid-RUN or in DONE SHALL abort the operation; the partial result SHALL be discarded and never presented.
REQ-020 The first accept SHALL be possible on the first edge after rst deasserts.

Configuration
REQ-021 Macro MP_ADD_SEQ_SUB_EN SHALL control subtraction support.
REQ-022 With MP_ADD_SEQ_SUB_EN defined, the block SHALL add a 1-bit input sub, sampled at accept; when sub=1, B_reg SHALL be stored inverted and the slice-0 carry-in SHALL be forced to 1, ignoring cin, so that sum = a-b and cout=1 means no borrow.
REQ-023 With MP_ADD_SEQ_SUB_EN undefined, port sub SHALL be absent, the block SHALL perform addition only, and logic SHALL be identical to sub tied to 0.

Structure
REQ-024 Package mp_add_pkg SHALL hold the state enum type (IDLE/RUN/DONE) and the SLICE_WIDTH=8 constant.
REQ-025 There SHALL be one sub-module, add_slice8: a combinational 8-bit adder with inputs a8, b8, ci and outputs s8, co, instantiated once and time-shared across slices.
REQ-026 The slice index SHALL be a counter of width clog2(N), minimum 1.

Verification
REQ-027 The bench SHALL check that a=0x000000FF, b=0x00000001, cin=0 gives out_valid 5 cycles after accept, with sum=0x00000100 and cout=0.
REQ-028 The bench SHALL check that a=0xFFFFFFFF, b=0x00000000, cin=1 gives sum=0x00000000 and cout=1, with the carry ripple across all 4 slices confirmed.
REQ-029 The bench SHALL check backpressure: with out_ready=0 for 10 cycles, out_valid stays 1, sum/cout stay stable, in_ready stays 0, and a new in_valid with a=0x12345678 is ignored; after out_ready=1, in_ready returns to 1 one cycle later.
REQ-030 The bench SHALL check reset mid-operation: rst for 1 cycle at RUN slice 2 gives IDLE, sum=0 and out_valid=0 on the next cycle; the next op a=0x11111111, b=0x22222222 gives sum=0x33333333.
REQ-031 With MP_ADD_SEQ_SUB_EN, the bench SHALL check that a=0x00000005, b=0x00000007, sub=1 gives sum=0xFFFFFFFE and cout=0, and that a=7, b=5, sub=1 gives sum=2 and cout=1.
REQ-032 The bench SHALL check back-to-back operation: 100 random ops with out_ready=1 and in_valid=1 match the reference model (a+b+cin) and show a period of exactly N+2 cycles.
